// File: rtl/slow_step_counter.sv
// slow_step_counter
// Treats the slow clock as a data input. It is synchronised into the clk domain
// and each rising edge becomes a one-cycle step pulse. That pulse drives an
// up/down LED counter. Three bouncy board buttons control the counter: one
// toggles run/pause, one toggles direction, and one clears the count. Every
// flop in this module is clocked by clk.
//
// Ports
//   clk        in   main clock
//   reset      in   synchronous, active-high reset
//   slow_in    in   slow clock, asynchronous to clk
//   btn_pause  in   raw button; a press toggles run/pause
//   btn_dir    in   raw button; a press toggles count direction
//   btn_clear  in   raw button; a press zeroes the counter
//   count      out  counter value (LEDs)
//   running    out  1 = RUN, 0 = PAUSE
//   dir_down   out  0 = count up, 1 = count down
//   step       out  one-cycle pulse per slow_in rising edge
//   wrap       out  one-cycle pulse when the count wraps
//
// FSM states
//   state    | meaning
//   ST_RUN   | steps advance the counter
//   ST_PAUSE | steps still pulse, but the counter holds
module slow_step_counter #(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             slow_in,
   input  logic             btn_pause,
   input  logic             btn_dir,
   input  logic             btn_clear,
   output logic [WIDTH-1:0] count,
   output logic             running,
   output logic             dir_down,
   output logic             step,
   output logic             wrap
);

   localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   // Debounce timers count down from this value. A button change is accepted
   // on terminal count, which is the DEBOUNCE_CYCLES-th consecutive cycle at
   // the new level.
   localparam logic [DW-1:0]    DB_LOAD = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

   // Button index: 0 = pause, 1 = dir, 2 = clear.
   localparam int B_PAUSE = 0;
   localparam int B_DIR   = 1;
   localparam int B_CLEAR = 2;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_PAUSE = 1'b1
   } state_t;

   logic                 slow_s1_q, slow_s1_d;
   logic                 slow_s2_q, slow_s2_d;
   logic                 slow_s3_q, slow_s3_d;
   logic                 step_q, step_d;
   logic [2:0]           btn_raw;
   logic [2:0]           btn_s1_q, btn_s1_d;
   logic [2:0]           btn_s2_q, btn_s2_d;
   logic [2:0]           stable_q, stable_d;
   logic [2:0]           press_q, press_d;
   logic [2:0][DW-1:0]   db_cnt_q, db_cnt_d;
   state_t               state_q, state_d;
   logic                 dir_q, dir_d;
   logic [WIDTH-1:0]     count_q, count_d;
   logic                 wrap_q, wrap_d;

   assign btn_raw = {btn_clear, btn_dir, btn_pause};

   always_comb begin
      slow_s1_d = slow_in;
      slow_s2_d = slow_s1_q;
      slow_s3_d = slow_s2_q;
      step_d    = slow_s2_q & ~slow_s3_q;

      btn_s1_d  = btn_raw;
      btn_s2_d  = btn_s1_q;
      stable_d  = stable_q;
      db_cnt_d  = db_cnt_q;
      for (int i = 0; i < 3; i++) begin
         db_cnt_d[i] = DB_LOAD;
         if (btn_s2_q[i] != stable_q[i]) begin
            if (db_cnt_q[i] == '0) begin
               stable_d[i] = btn_s2_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] - 1'b1;
            end
         end
      end
      // Only a 0->1 change of the stable level is an event; a release is ignored.
      press_d = stable_d & ~stable_q;
   end

   always_comb begin
      state_d = state_q;
      if (press_q[B_PAUSE]) begin
         state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
      end
      dir_d = dir_q ^ press_q[B_DIR];
   end

   // The step is applied with the current state and direction. Any toggle
   // pressed in the same cycle takes effect from the next cycle.
   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      if (press_q[B_CLEAR]) begin
         count_d = '0;
      end else if (step_q && (state_q == ST_RUN)) begin
         if (dir_q) begin
            count_d = count_q - ONE;
            wrap_d  = (count_q == '0);
         end else begin
            count_d = count_q + ONE;
            wrap_d  = &count_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         slow_s1_q <= 1'b0;
         slow_s2_q <= 1'b0;
         slow_s3_q <= 1'b0;
         step_q    <= 1'b0;
         btn_s1_q  <= '0;
         btn_s2_q  <= '0;
         stable_q  <= '0;
         press_q   <= '0;
         db_cnt_q  <= {3{DB_LOAD}};
         state_q   <= ST_RUN;
         dir_q     <= 1'b0;
         count_q   <= '0;
         wrap_q    <= 1'b0;
      end else begin
         slow_s1_q <= slow_s1_d;
         slow_s2_q <= slow_s2_d;
         slow_s3_q <= slow_s3_d;
         step_q    <= step_d;
         btn_s1_q  <= btn_s1_d;
         btn_s2_q  <= btn_s2_d;
         stable_q  <= stable_d;
         press_q   <= press_d;
         db_cnt_q  <= db_cnt_d;
         state_q   <= state_d;
         dir_q     <= dir_d;
         count_q   <= count_d;
         wrap_q    <= wrap_d;
      end
   end

   assign count    = count_q;
   assign running  = (state_q == ST_RUN);
   assign dir_down = dir_q;
   assign step     = step_q;
   assign wrap     = wrap_q;

endmodule
